score_display_ctrl: RTL and testbench
=====================================

# score_display_ctrl

Sequential controller that drives the four-digit, common-anode seven-segment display from a binary score. A load request converts a 14-bit binary value to four BCD digits with a multi-cycle shift-add-3 (double-dabble) engine and commits them to a display register. A refresh scanner then time-multiplexes the digits: each cycle it presents one digit code to the existing active-low single-digit segment decoder and enables the matching anode. The block sits between the game-state logic, which supplies the score, and the segment decoder and board pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays enabled (1 ms at 100 MHz); legal range 2..2^20.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to display `value`.
- `value`  in  14  binary score; values above 9999 saturate to 9999.
- `busy`  out  1  conversion in progress.
- `digit`  out  4  BCD code for the segment decoder's `num`; 4'hF = blank.
- `an`  out  4  anode enables, active-low, one-hot-low; bit 0 = least-significant digit.
- `disp_bcd`  out  16  committed BCD value, `{thousands, hundreds, tens, ones}`.

## Operation
- Reset values: `busy`=0, `disp_bcd`=16'h0000, `an`=4'b1110, `digit`=4'h0, divider=0, scan index=0, FSM=IDLE, pending flag=0.
- FSM states:
  - IDLE: on `load`, capture min(`value`, 9999) into the shift register, clear the BCD accumulator, clear the shift count, and go to CONVERT.
  - CONVERT: 14 iterations. Each cycle, add 3 to every BCD nibble that is ≥5, then shift the combined {BCD, binary} register left by 1. After the 14th shift, go to COMMIT.
  - COMMIT: write the accumulator to `disp_bcd`. If the pending flag is set, clear it, start a new conversion from the pending value, and go to CONVERT. Otherwise go to IDLE.
- `load` while `busy`=1: latch min(`value`, 9999) into the pending register and set the pending flag. A later `load` overwrites the pending value (last one wins). The running conversion is never aborted.
- `load` in the same cycle as COMMIT with no pending flag: treat as pending, so it runs immediately after COMMIT.
- Scanner:
  - The divider counts 0..`REFRESH_DIV`-1 and runs regardless of FSM state.
  - On wrap, the scan index advances 0→1→2→3→0.
  - `an` = ~(1 << index).
  - `digit` = nibble[index] of `disp_bcd`.
- `disp_bcd` changes only in COMMIT, so the display never shows a partially converted value.

## Timing
- `load` sampled at edge k:
  - `busy`=1 after edge k.
  - Shifts occur at edges k+1..k+14.
  - COMMIT at edge k+15: `disp_bcd` is updated and `busy`=0 after edge k+15 (if no pending request).
- Back-to-back request: a pending conversion restarts at edge k+15, so `busy` stays high continuously and the second result commits at edge k+30.
- `an` and `digit` are registered and reflect scan index and `disp_bcd` one cycle after either changes.
- One full refresh frame is 4×`REFRESH_DIV` cycles.
- `rst` mid-conversion: all state returns to its reset value at the next edge, and the pending request is discarded.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Digits 3..1 are blanked while they and all higher digits are zero.
  - A blanked digit drives `digit`=4'hF and `an`=4'b1111 during its slot.
  - Digit 0 is never blanked.
- Undefined: all four digits always display, including leading zeros.

## Test plan
- Reset: assert `rst` 2 cycles → `an`=4'b1110, `digit`=0, `disp_bcd`=16'h0000, `busy`=0.
- Conversion: `load` with `value`=1234 → `busy` high for exactly 15 cycles, then `disp_bcd`=16'h1234.
- Scan, `REFRESH_DIV`=4: after committing 16'h1234, `an` cycles 1110→1101→1011→0111 every 4 cycles with `digit` 4→3→2→1, then wraps.
- Saturation and pending: `load` 12000, then `load` 42 at cycle +5 → `disp_bcd`=16'h9999 at +15, then 16'h0042 at +30.
- Blanking (macro defined): commit 7 → digit-0 slot shows `an`=1110/`digit`=7, other slots show `an`=1111/`digit`=F. With the macro undefined → all slots enabled showing 0,0,0,7.
- Reset mid-operation: `rst` at cycle 6 of a conversion with a pending request → `disp_bcd` stays 0, `busy`=0, and no later commit occurs.

Source files
------------

// File: rtl/score_display_ctrl_if.sv
// score_display_ctrl_if: score load request and display-drive signals of score_display_ctrl
interface score_display_ctrl_if;
    logic        load;
    logic [13:0] value;
    logic        busy;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [15:0] disp_bcd;
    modport master(output load, value, input busy, digit, an, disp_bcd);
    modport slave(input load, value, output busy, digit, an, disp_bcd);
endinterface

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: binary score to BCD (double dabble) plus 4-digit multiplexed display scanner
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module score_display_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input logic clk,
    input logic rst,
    score_display_ctrl_if.slave bus
);
    localparam int DW = $clog2(REFRESH_DIV);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t state, state_n;
    logic [13:0] bin, pend_val, sat, start_val;
    logic [15:0] bcd, adj, disp;
    logic [3:0]  cnt, an, digit;
    logic        pend, start, blank, wrap;
    logic [DW-1:0] div;
    logic [1:0]  idx;
    assign sat = bus.value > 14'd9999 ? 14'd9999 : bus.value;
    assign bus.busy = state != IDLE;
    assign bus.disp_bcd = disp;
    assign bus.an = an;
    assign bus.digit = digit;
    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign adj[4*g +: 4] = bcd[4*g +: 4] >= 4'd5 ? bcd[4*g +: 4] + 4'd3 : bcd[4*g +: 4];
    end
    // A load arriving during COMMIT is newer than any pending value, so it wins.
    always_comb begin
        state_n = state;
        start = 1'b0;
        start_val = sat;
        case (state)
            IDLE: begin
                start = bus.load;
                state_n = bus.load ? CONVERT : IDLE;
            end
            CONVERT: state_n = cnt == 4'd13 ? COMMIT : CONVERT;
            COMMIT: begin
                start = bus.load || pend;
                start_val = bus.load ? sat : pend_val;
                state_n = start ? CONVERT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
            pend <= 1'b0;
            pend_val <= '0;
            disp <= '0;
        end else begin
            if (start) begin
                bin <= start_val;
                bcd <= '0;
                cnt <= '0;
            end else if (state == CONVERT) begin
                {bcd, bin} <= {adj[14:0], bin, 1'b0};
                cnt <= cnt + 4'd1;
            end
            if (start) pend <= 1'b0;
            else if (bus.load) begin
                pend <= 1'b1;
                pend_val <= sat;
            end
            if (state == COMMIT) disp <= bcd;
        end
    end
`ifdef LEADING_ZERO_BLANK_EN
    assign blank = idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'h0;
`else
    assign blank = 1'b0;
`endif
    assign wrap = div == DW'(REFRESH_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
            an <= 4'b1110;
            digit <= 4'h0;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            idx <= idx + {1'b0, wrap};
            an <= blank ? 4'b1111 : ~(4'b0001 << idx);
            digit <= blank ? 4'hF : disp[{idx, 2'b00} +: 4];
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed vector bench for score_display_ctrl with REFRESH_DIV=4
module tb_score_display_ctrl;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    score_display_ctrl_if bus();
    score_display_ctrl #(.REFRESH_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [13:0] value;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic pulse_load(input logic [13:0] v);
        bus.value = v;
        bus.load = 1'b1;
        tick(1);
        bus.load = 1'b0;
    endtask
    task automatic do_reset;
        bus.load = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask
    task automatic conv(input logic [13:0] v, input logic [15:0] exp);
        int n = 0;
        pulse_load(v);
        while (bus.busy && n < 40) begin
            n++;
            tick(1);
        end
        chk("busy_cycles", n, 15);
        chk("disp_bcd", bus.disp_bcd, exp);
    endtask
    task automatic scan_check(input logic [15:0] val);
        logic [3:0] prev, e_an, e_dig;
        logic found = 1'b0;
        logic bl;
        int i;
        prev = bus.an;
        for (int c = 0; c < 40 && !found; c++) begin
            tick(1);
            if (bus.an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = bus.an;
        end
        chk("scan_sync", found, 1);
        if (found) begin
            for (int s = 0; s < 8; s++) begin
                i = s % 4;
`ifdef LEADING_ZERO_BLANK_EN
                bl = i != 0 && (val >> (4 * i)) == 16'h0;
`else
                bl = 1'b0;
`endif
                e_an = bl ? 4'b1111 : ~(4'b0001 << i);
                e_dig = bl ? 4'hF : val[4*i +: 4];
                chk("scan_an", bus.an, e_an);
                chk("scan_digit", bus.digit, e_dig);
                tick(4);
            end
        end
    endtask
    initial begin
        vecs[0] = '{14'd0, 16'h0000};
        vecs[1] = '{14'd1234, 16'h1234};
        vecs[2] = '{14'd9999, 16'h9999};
        vecs[3] = '{14'd10000, 16'h9999};
        vecs[4] = '{14'd16383, 16'h9999};
        vecs[5] = '{14'd7, 16'h0007};
        vecs[6] = '{14'd42, 16'h0042};
        vecs[7] = '{14'd5, 16'h0005};
        vecs[8] = '{14'd8000, 16'h8000};
        vecs[9] = '{14'd905, 16'h0905};
        rst = 1'b1;
        bus.load = 1'b0;
        bus.value = '0;
        tick(2);
        chk("rst_an", bus.an, 4'b1110);
        chk("rst_digit", bus.digit, 4'h0);
        chk("rst_disp", bus.disp_bcd, 16'h0000);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick(1);
        for (int v = 0; v < 10; v++) conv(vecs[v].value, vecs[v].exp);
        conv(14'd1234, 16'h1234);
        scan_check(16'h1234);
        conv(14'd7, 16'h0007);
        scan_check(16'h0007);
        // saturating load followed by a pending load five cycles later
        do_reset();
        pulse_load(14'd12000);
        tick(4);
        pulse_load(14'd42);
        tick(9);
        chk("pend_k14_disp", bus.disp_bcd, 16'h0000);
        tick(1);
        chk("pend_k15_disp", bus.disp_bcd, 16'h9999);
        chk("pend_k15_busy", bus.busy, 1'b1);
        tick(14);
        chk("pend_k29_disp", bus.disp_bcd, 16'h9999);
        chk("pend_k29_busy", bus.busy, 1'b1);
        tick(1);
        chk("pend_k30_disp", bus.disp_bcd, 16'h0042);
        chk("pend_k30_busy", bus.busy, 1'b0);
        // load landing exactly on the COMMIT cycle
        pulse_load(14'd100);
        tick(14);
        pulse_load(14'd200);
        chk("cmt_k15_disp", bus.disp_bcd, 16'h0100);
        chk("cmt_k15_busy", bus.busy, 1'b1);
        tick(15);
        chk("cmt_k30_disp", bus.disp_bcd, 16'h0200);
        chk("cmt_k30_busy", bus.busy, 1'b0);
        // reset in the middle of a conversion with a pending request
        do_reset();
        pulse_load(14'd1234);
        tick(1);
        pulse_load(14'd55);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_disp", bus.disp_bcd, 16'h0000);
        chk("mid_rst_an", bus.an, 4'b1110);
        chk("mid_rst_digit", bus.digit, 4'h0);
        tick(40);
        chk("mid_rst_late_disp", bus.disp_bcd, 16'h0000);
        chk("mid_rst_late_busy", bus.busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
